// File: rtl/oled_spi_driver_if.sv
// Byte/sync request handshake between the digit data streamer and the OLED SPI driver.
interface oled_spi_driver_if;
    logic [7:0] data_in;
    logic       write_stb_in;
    logic       sync_stb_in;
    logic       ready_out;

    modport master (
        output data_in,
        output write_stb_in,
        output sync_stb_in,
        input  ready_out
    );

    modport slave (
        input  data_in,
        input  write_stb_in,
        input  sync_stb_in,
        output ready_out
    );
endinterface

// File: rtl/oled_spi_driver.sv
// SSD1306 4-wire SPI driver: panel reset pulse, init ROM playback, then data bytes (D/C=1)
// and GDDRAM window re-home command blocks (D/C=0) on request.
module oled_spi_driver #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned RST_CYCLES = 16
) (
    input  logic             clk_in,
    input  logic             reset_in,
    oled_spi_driver_if.slave host_if,
    output logic             spi_sck_out,
    output logic             spi_mosi_out,
    output logic             spi_cs_n_out,
    output logic             spi_dc_out,
    output logic             oled_rst_n_out
);
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [RstW-1:0] RstLast   = RstW'(RST_CYCLES - 1);
    localparam logic [4:0]      InitLast  = 5'd24;
    localparam logic [4:0]      SyncFirst = 5'd25;
    localparam logic [4:0]      SyncLast  = 5'd30;

    typedef enum logic [2:0] {
        S_RST_LOW, S_RST_HIGH, S_INIT, S_IDLE, S_DATA, S_SYNC
    } state_t;

    state_t          r_state, w_state_next;
    logic [RstW-1:0] r_rst_cnt, w_rst_cnt_next;
    logic [DivW-1:0] r_div, w_div_next;
    logic [2:0]      r_bit, w_bit_next;
    logic [4:0]      r_idx, w_idx_next;
    logic [7:0]      r_shift, w_shift_next;
    logic            r_sck, w_sck_next;
    logic            r_cs_n, w_cs_n_next;
    logic            r_dc, w_dc_next;
    logic            r_gap, w_gap_next;
    logic            r_oled_rst_n, w_oled_rst_n_next;
    logic            w_load;
    logic [7:0]      w_load_byte;
    logic            w_last_byte;

    // Init sequence at 0..24, address-window block at 25..30.
    function automatic logic [7:0] rom_byte(input logic [4:0] idx);
        case (idx)
            5'd0:    rom_byte = 8'hAE;
            5'd1:    rom_byte = 8'hD5;
            5'd2:    rom_byte = 8'h80;
            5'd3:    rom_byte = 8'hA8;
            5'd4:    rom_byte = 8'h1F;
            5'd5:    rom_byte = 8'hD3;
            5'd6:    rom_byte = 8'h00;
            5'd7:    rom_byte = 8'h40;
            5'd8:    rom_byte = 8'h8D;
            5'd9:    rom_byte = 8'h14;
            5'd10:   rom_byte = 8'h20;
            5'd11:   rom_byte = 8'h00;
            5'd12:   rom_byte = 8'hA1;
            5'd13:   rom_byte = 8'hC8;
            5'd14:   rom_byte = 8'hDA;
            5'd15:   rom_byte = 8'h02;
            5'd16:   rom_byte = 8'h81;
            5'd17:   rom_byte = 8'h8F;
            5'd18:   rom_byte = 8'hD9;
            5'd19:   rom_byte = 8'hF1;
            5'd20:   rom_byte = 8'hDB;
            5'd21:   rom_byte = 8'h40;
            5'd22:   rom_byte = 8'hA4;
            5'd23:   rom_byte = 8'hA6;
            5'd24:   rom_byte = 8'hAF;
            5'd25:   rom_byte = 8'h21;
            5'd26:   rom_byte = 8'h00;
            5'd27:   rom_byte = 8'h7F;
            5'd28:   rom_byte = 8'h22;
            5'd29:   rom_byte = 8'h00;
            5'd30:   rom_byte = 8'h03;
            default: rom_byte = 8'h00;
        endcase
    endfunction

    always_comb begin
        w_state_next      = r_state;
        w_rst_cnt_next    = r_rst_cnt;
        w_div_next        = r_div;
        w_bit_next        = r_bit;
        w_idx_next        = r_idx;
        w_shift_next      = r_shift;
        w_sck_next        = r_sck;
        w_cs_n_next       = r_cs_n;
        w_dc_next         = r_dc;
        w_gap_next        = r_gap;
        w_oled_rst_n_next = r_oled_rst_n;
        w_load            = 1'b0;
        w_load_byte       = 8'h00;
        w_last_byte       = (r_state == S_DATA) ||
                            ((r_state == S_INIT) && (r_idx == InitLast)) ||
                            ((r_state == S_SYNC) && (r_idx == SyncLast));

        case (r_state)
            S_RST_LOW: begin
                if (r_rst_cnt == RstLast) begin
                    w_state_next      = S_RST_HIGH;
                    w_rst_cnt_next    = '0;
                    w_oled_rst_n_next = 1'b1;
                end else begin
                    w_rst_cnt_next = r_rst_cnt + 1'b1;
                end
            end
            S_RST_HIGH: begin
                if (r_rst_cnt == RstLast) begin
                    w_state_next = S_INIT;
                    w_idx_next   = 5'd0;
                    w_dc_next    = 1'b0;
                    w_load       = 1'b1;
                    w_load_byte  = rom_byte(5'd0);
                end else begin
                    w_rst_cnt_next = r_rst_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                // Sync has priority; a simultaneous write is dropped.
                if (host_if.sync_stb_in) begin
                    w_state_next = S_SYNC;
                    w_idx_next   = SyncFirst;
                    w_dc_next    = 1'b0;
                    w_load       = 1'b1;
                    w_load_byte  = rom_byte(SyncFirst);
                end else if (host_if.write_stb_in) begin
                    w_state_next = S_DATA;
                    w_dc_next    = 1'b1;
                    w_load       = 1'b1;
                    w_load_byte  = host_if.data_in;
                end
            end
            S_INIT, S_DATA, S_SYNC: begin
                if (r_div != DivLast) begin
                    w_div_next = r_div + 1'b1;
                end else if (r_gap) begin
                    w_div_next = '0;
                    w_gap_next = 1'b0;
                    if (w_last_byte) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_idx_next  = r_idx + 5'd1;
                        w_load      = 1'b1;
                        w_load_byte = rom_byte(r_idx + 5'd1);
                    end
                end else if (!r_sck) begin
                    w_div_next = '0;
                    w_sck_next = 1'b1;
                end else begin
                    w_div_next = '0;
                    w_sck_next = 1'b0;
                    if (r_bit == 3'd0) begin
                        w_cs_n_next = 1'b1;
                        w_gap_next  = 1'b1;
                    end else begin
                        w_bit_next   = r_bit - 3'd1;
                        w_shift_next = {r_shift[6:0], 1'b0};
                    end
                end
            end
            default: w_state_next = S_RST_LOW;
        endcase

        if (w_load) begin
            w_shift_next = w_load_byte;
            w_bit_next   = 3'd7;
            w_div_next   = '0;
            w_sck_next   = 1'b0;
            w_gap_next   = 1'b0;
            w_cs_n_next  = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state      <= S_RST_LOW;
            r_rst_cnt    <= '0;
            r_div        <= '0;
            r_bit        <= 3'd7;
            r_idx        <= 5'd0;
            r_shift      <= 8'h00;
            r_sck        <= 1'b0;
            r_cs_n       <= 1'b1;
            r_dc         <= 1'b0;
            r_gap        <= 1'b0;
            r_oled_rst_n <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_rst_cnt    <= w_rst_cnt_next;
            r_div        <= w_div_next;
            r_bit        <= w_bit_next;
            r_idx        <= w_idx_next;
            r_shift      <= w_shift_next;
            r_sck        <= w_sck_next;
            r_cs_n       <= w_cs_n_next;
            r_dc         <= w_dc_next;
            r_gap        <= w_gap_next;
            r_oled_rst_n <= w_oled_rst_n_next;
        end
    end

    assign host_if.ready_out = (r_state == S_IDLE);
    assign spi_sck_out       = r_sck;
    assign spi_mosi_out      = r_shift[7];
    assign spi_cs_n_out      = r_cs_n;
    assign spi_dc_out        = r_dc;
    assign oled_rst_n_out    = r_oled_rst_n;
endmodule
